// File: rtl/pong_pkg.sv
// Shared geometry, state encoding and colours for the Pong engine.
// All on-screen arithmetic uses 12-bit signed coordinates so that off-screen ball positions compare correctly.
package pong_pkg;

    typedef logic signed [11:0] coord_t;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    localparam coord_t SCREEN_W  = 12'sd800;
    localparam coord_t SCREEN_H  = 12'sd600;
    localparam coord_t PADDLE_W  = 12'sd10;
    localparam coord_t PADDLE_H  = 12'sd80;
    localparam coord_t PADDLE_XL = 12'sd20;
    localparam coord_t PADDLE_XR = 12'sd770;
    localparam coord_t BALL_SZ   = 12'sd10;
    localparam coord_t BALL_SPD  = 12'sd4;

    localparam coord_t BALL_X0   = 12'sd395;
    localparam coord_t BALL_Y0   = 12'sd295;
    localparam coord_t HIT_XL    = PADDLE_XL + PADDLE_W;
    localparam coord_t HIT_XR    = PADDLE_XR - BALL_SZ;
    localparam coord_t BALL_XMAX = SCREEN_W - BALL_SZ;
    localparam coord_t BALL_YMAX = SCREEN_H - BALL_SZ;
    localparam coord_t CENTRE_X0 = 12'sd399;
    localparam coord_t CENTRE_X1 = 12'sd400;

    localparam logic [9:0] PADDLE_SPD = 10'd6;
    localparam logic [9:0] PADDLE_MAX = 10'd520;
    localparam logic [9:0] PADDLE_Y0  = 10'd260;

    localparam logic [5:0] SERVE_FRAMES = 6'd60;
    localparam logic [3:0] WIN_SCORE    = 4'd9;

    localparam logic [11:0] WHITE    = 12'hFFF;
    localparam logic [11:0] GREY     = 12'h888;
    localparam logic [11:0] BLACK    = 12'h000;
    localparam logic [11:0] DARK_RED = 12'h400;

    // True when a ball whose top edge is ball_top shares any row with a paddle starting at pad_top.
    function automatic logic v_overlap(input coord_t ball_top, input coord_t pad_top);
        return (ball_top + BALL_SZ > pad_top) && (ball_top < pad_top + PADDLE_H);
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// Saturating paddle y register; a simultaneous up+dn request holds position.
module pong_paddle
    import pong_pkg::*;
#(
    parameter logic [9:0] STEP = PADDLE_SPD,
    parameter logic [9:0] MAX  = PADDLE_MAX,
    parameter logic [9:0] INIT = PADDLE_Y0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= INIT;
        end else if (load) begin
            y <= INIT;
        end else if (en && up && !dn) begin
            y <= (y < STEP) ? 10'd0 : y - STEP;
        end else if (en && dn && !up) begin
            y <= (y > MAX - STEP) ? MAX : y + STEP;
        end
    end

endmodule

// File: rtl/pong_game.sv
// Frame-rate Pong engine: game FSM, ball physics and scoring on each animate tick,
// plus a registered one-cycle-latency pixel renderer for the VGA DAC.
module pong_game
    import pong_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_animate,
    input  logic        i_active,
    input  logic [10:0] i_x,
    input  logic [9:0]  i_y,
    input  logic        i_l_up,
    input  logic        i_l_dn,
    input  logic        i_r_up,
    input  logic        i_r_dn,
    output logic [11:0] o_rgb,
    output logic [3:0]  o_score_l,
    output logic [3:0]  o_score_r,
    output logic        o_game_over
);

    state_t     state, state_n;
    logic [5:0] serve_cnt, serve_cnt_n;
    coord_t     ball_x, ball_y, ball_x_n, ball_y_n;
    logic       dx_pos, dy_pos, dx_pos_n, dy_pos_n;
    logic [3:0] score_l, score_r, score_l_n, score_r_n;
    logic [9:0] paddle_l_y, paddle_r_y;
    coord_t     nx, ny, pad_l, pad_r, px, py;
    logic       hit_l, hit_r, any_btn, restart, paddle_en;
    logic       in_ball, in_paddle, in_centre;
    logic [11:0] rgb_n;

    assign any_btn   = i_l_up | i_l_dn | i_r_up | i_r_dn;
    assign restart   = i_animate && (state == GAME_OVER) && any_btn;
    assign paddle_en = i_animate && (state != GAME_OVER);

    pong_paddle #(.STEP(PADDLE_SPD), .MAX(PADDLE_MAX), .INIT(PADDLE_Y0)) u_paddle_l (
        .clk(i_clk), .rst_n(i_rst_n), .en(paddle_en), .load(restart),
        .up(i_l_up), .dn(i_l_dn), .y(paddle_l_y)
    );

    pong_paddle #(.STEP(PADDLE_SPD), .MAX(PADDLE_MAX), .INIT(PADDLE_Y0)) u_paddle_r (
        .clk(i_clk), .rst_n(i_rst_n), .en(paddle_en), .load(restart),
        .up(i_r_up), .dn(i_r_dn), .y(paddle_r_y)
    );

    // Collision tests deliberately use the paddle positions from before this frame's move.
    assign pad_l = $signed({2'b00, paddle_l_y});
    assign pad_r = $signed({2'b00, paddle_r_y});
    assign nx    = ball_x + (dx_pos ? BALL_SPD : -BALL_SPD);
    assign ny    = ball_y + (dy_pos ? BALL_SPD : -BALL_SPD);
    assign hit_l = !dx_pos && (nx <= HIT_XL) && (ball_x >= HIT_XL) && v_overlap(ny, pad_l);
    assign hit_r = dx_pos && (nx >= HIT_XR) && (ball_x <= HIT_XR) && v_overlap(ny, pad_r);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= SERVE;
            serve_cnt <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            dx_pos    <= 1'b1;
            dy_pos    <= 1'b1;
            score_l   <= '0;
            score_r   <= '0;
        end else begin
            state     <= state_n;
            serve_cnt <= serve_cnt_n;
            ball_x    <= ball_x_n;
            ball_y    <= ball_y_n;
            dx_pos    <= dx_pos_n;
            dy_pos    <= dy_pos_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
        end
    end

    // Wall bounce and paddle bounce are independent, so a corner hit flips both directions.
    always_comb begin
        state_n     = state;
        serve_cnt_n = serve_cnt;
        ball_x_n    = ball_x;
        ball_y_n    = ball_y;
        dx_pos_n    = dx_pos;
        dy_pos_n    = dy_pos;
        score_l_n   = score_l;
        score_r_n   = score_r;
        if (i_animate) begin
            case (state)
                SERVE: begin
                    if (serve_cnt == SERVE_FRAMES - 6'd1) begin
                        state_n     = PLAY;
                        serve_cnt_n = '0;
                    end else begin
                        serve_cnt_n = serve_cnt + 6'd1;
                    end
                end
                PLAY: begin
                    ball_x_n = nx;
                    ball_y_n = ny;
                    if (ny <= 12'sd0) begin
                        ball_y_n = 12'sd0;
                        dy_pos_n = 1'b1;
                    end else if (ny >= BALL_YMAX) begin
                        ball_y_n = BALL_YMAX;
                        dy_pos_n = 1'b0;
                    end
                    if (hit_l) begin
                        ball_x_n = HIT_XL;
                        dx_pos_n = 1'b1;
                    end else if (hit_r) begin
                        ball_x_n = HIT_XR;
                        dx_pos_n = 1'b0;
                    end else if (nx <= 12'sd0) begin
                        score_r_n = (score_r == WIN_SCORE) ? score_r : score_r + 4'd1;
                        ball_x_n  = BALL_X0;
                        ball_y_n  = BALL_Y0;
                        dx_pos_n  = 1'b0;
                        dy_pos_n  = dy_pos;
                        state_n   = (score_r_n == WIN_SCORE) ? GAME_OVER : SERVE;
                    end else if (nx >= BALL_XMAX) begin
                        score_l_n = (score_l == WIN_SCORE) ? score_l : score_l + 4'd1;
                        ball_x_n  = BALL_X0;
                        ball_y_n  = BALL_Y0;
                        dx_pos_n  = 1'b1;
                        dy_pos_n  = dy_pos;
                        state_n   = (score_l_n == WIN_SCORE) ? GAME_OVER : SERVE;
                    end
                end
                GAME_OVER: begin
                    if (any_btn) begin
                        state_n     = SERVE;
                        serve_cnt_n = '0;
                        ball_x_n    = BALL_X0;
                        ball_y_n    = BALL_Y0;
                        dx_pos_n    = 1'b1;
                        dy_pos_n    = 1'b1;
                        score_l_n   = '0;
                        score_r_n   = '0;
                    end
                end
                default: state_n = SERVE;
            endcase
        end
    end

    assign px = $signed({1'b0, i_x});
    assign py = $signed({2'b00, i_y});
    assign in_ball   = (px >= ball_x) && (px < ball_x + BALL_SZ) && (py >= ball_y) && (py < ball_y + BALL_SZ);
    assign in_paddle = ((px >= PADDLE_XL) && (px < PADDLE_XL + PADDLE_W) && (py >= pad_l) && (py < pad_l + PADDLE_H))
                    || ((px >= PADDLE_XR) && (px < PADDLE_XR + PADDLE_W) && (py >= pad_r) && (py < pad_r + PADDLE_H));
    assign in_centre = (px >= CENTRE_X0) && (px <= CENTRE_X1) && !i_y[4];

    always_comb begin
        rgb_n = BLACK;
        if (!i_active)      rgb_n = BLACK;
        else if (in_ball)   rgb_n = WHITE;
        else if (in_paddle) rgb_n = WHITE;
        else if (in_centre) rgb_n = GREY;
        else                rgb_n = (state == GAME_OVER) ? DARK_RED : BLACK;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_rgb <= BLACK;
        else          o_rgb <= rgb_n;
    end

    assign o_score_l   = score_l;
    assign o_score_r   = score_r;
    assign o_game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game: serve timing, paddles, bounces, misses, game over and renderer.
// Expected ball trajectories were worked out by hand from the centre launch point.
module tb_pong_game;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        animate = 1'b0;
    logic        active = 1'b0;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
    logic [11:0] rgb;
    logic [3:0]  score_l, score_r;
    logic        game_over;
    int          checks = 0;
    int          passes = 0;

    pong_game dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_animate(animate), .i_active(active),
        .i_x(x), .i_y(y), .i_l_up(l_up), .i_l_dn(l_dn), .i_r_up(r_up), .i_r_dn(r_dn),
        .o_rgb(rgb), .o_score_l(score_l), .o_score_r(score_r), .o_game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            animate = 1'b1;
            step();
            animate = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        l_up = 0; l_dn = 0; r_up = 0; r_dn = 0; animate = 0; active = 0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        frames(65);
        x = 11'd415; y = 10'd315; active = 1'b1;
        step();
        checks++; if (rgb !== 12'hFFF) $display("[TB] FAIL moved_ball_pixel: got %h expected fff", rgb); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rgb !== 12'h000) $display("[TB] FAIL async_reset_rgb: got %h expected 000", rgb); else passes++;
        checks++; if ({dut.ball_x, dut.ball_y} !== {12'd395, 12'd295})
            $display("[TB] FAIL reset_ball: got (%0d,%0d) expected (395,295)", dut.ball_x, dut.ball_y); else passes++;
        checks++; if ({dut.state, dut.dx_pos, dut.dy_pos} !== {2'd0, 1'b1, 1'b1})
            $display("[TB] FAIL reset_state_dir: got %0d/%0b%0b expected 0/11", dut.state, dut.dx_pos, dut.dy_pos); else passes++;
        checks++; if ({score_l, score_r, game_over} !== 9'd0)
            $display("[TB] FAIL reset_scores: got %0d/%0d/%0b expected 0/0/0", score_l, score_r, game_over); else passes++;
        checks++; if ({dut.paddle_l_y, dut.paddle_r_y} !== {10'd260, 10'd260})
            $display("[TB] FAIL reset_paddles: got %0d/%0d expected 260/260", dut.paddle_l_y, dut.paddle_r_y); else passes++;
        step();
        checks++; if (rgb !== 12'h000) $display("[TB] FAIL rgb_held_in_reset: got %h expected 000", rgb); else passes++;
        rst_n = 1'b1; x = 11'd395; y = 10'd295;
        #1;
        checks++; if (rgb !== 12'h000) $display("[TB] FAIL rgb_before_first_clock: got %h expected 000", rgb); else passes++;
        step();
        checks++; if (rgb !== 12'hFFF) $display("[TB] FAIL rgb_after_release: got %h expected fff", rgb); else passes++;
        active = 1'b0;
        step();
    endtask

    task automatic test_serve();
        do_reset();
        frames(59);
        checks++; if (dut.state !== 2'd0) $display("[TB] FAIL serve_59: got state %0d expected 0", dut.state); else passes++;
        frames(1);
        checks++; if (dut.state !== 2'd1) $display("[TB] FAIL serve_60: got state %0d expected 1", dut.state); else passes++;
        checks++; if ({dut.ball_x, dut.ball_y} !== {12'd395, 12'd295})
            $display("[TB] FAIL launch_hold: got (%0d,%0d) expected (395,295)", dut.ball_x, dut.ball_y); else passes++;
        frames(1);
        checks++; if ({dut.ball_x, dut.ball_y} !== {12'd399, 12'd299})
            $display("[TB] FAIL first_move: got (%0d,%0d) expected (399,299)", dut.ball_x, dut.ball_y); else passes++;
    endtask

    task automatic test_paddle();
        do_reset();
        l_up = 1'b1; r_dn = 1'b1;
        frames(1);
        checks++; if ({dut.paddle_l_y, dut.paddle_r_y} !== {10'd254, 10'd266})
            $display("[TB] FAIL paddle_f1: got %0d/%0d expected 254/266", dut.paddle_l_y, dut.paddle_r_y); else passes++;
        frames(1);
        checks++; if (dut.paddle_l_y !== 10'd248) $display("[TB] FAIL paddle_f2: got %0d expected 248", dut.paddle_l_y); else passes++;
        frames(41);
        checks++; if ({dut.paddle_l_y, dut.paddle_r_y} !== {10'd2, 10'd518})
            $display("[TB] FAIL paddle_f43: got %0d/%0d expected 2/518", dut.paddle_l_y, dut.paddle_r_y); else passes++;
        frames(1);
        checks++; if ({dut.paddle_l_y, dut.paddle_r_y} !== {10'd0, 10'd520})
            $display("[TB] FAIL paddle_sat: got %0d/%0d expected 0/520", dut.paddle_l_y, dut.paddle_r_y); else passes++;
        frames(6);
        checks++; if ({dut.paddle_l_y, dut.paddle_r_y} !== {10'd0, 10'd520})
            $display("[TB] FAIL paddle_f50: got %0d/%0d expected 0/520", dut.paddle_l_y, dut.paddle_r_y); else passes++;
        l_dn = 1'b1; r_up = 1'b1;
        frames(1);
        checks++; if ({dut.paddle_l_y, dut.paddle_r_y} !== {10'd0, 10'd520})
            $display("[TB] FAIL paddle_both: got %0d/%0d expected 0/520", dut.paddle_l_y, dut.paddle_r_y); else passes++;
        l_up = 1'b0; r_dn = 1'b0;
        frames(1);
        checks++; if ({dut.paddle_l_y, dut.paddle_r_y} !== {10'd6, 10'd514})
            $display("[TB] FAIL paddle_reverse: got %0d/%0d expected 6/514", dut.paddle_l_y, dut.paddle_r_y); else passes++;
        l_dn = 1'b0; r_up = 1'b0;
    endtask

    task automatic test_bounce_and_miss();
        do_reset();
        r_dn = 1'b1;
        frames(60);
        r_dn = 1'b0;
        frames(74);
        checks++; if ({dut.ball_x, dut.ball_y, dut.dy_pos} !== {12'd691, 12'd590, 1'b0})
            $display("[TB] FAIL bottom_wall: got (%0d,%0d) dy %0b expected (691,590) dy 0", dut.ball_x, dut.ball_y, dut.dy_pos); else passes++;
        frames(18);
        checks++; if ({dut.ball_x, dut.ball_y, dut.dx_pos} !== {12'd760, 12'd518, 1'b0})
            $display("[TB] FAIL right_paddle: got (%0d,%0d) dx %0b expected (760,518) dx 0", dut.ball_x, dut.ball_y, dut.dx_pos); else passes++;
        frames(130);
        checks++; if ({dut.ball_x, dut.ball_y, dut.dy_pos} !== {12'd240, 12'd0, 1'b1})
            $display("[TB] FAIL top_wall: got (%0d,%0d) dy %0b expected (240,0) dy 1", dut.ball_x, dut.ball_y, dut.dy_pos); else passes++;
        frames(53);
        checks++; if ({dut.ball_x, dut.ball_y, score_r} !== {12'd28, 12'd212, 4'd0})
            $display("[TB] FAIL past_left_paddle: got (%0d,%0d) score_r %0d expected (28,212) 0", dut.ball_x, dut.ball_y, score_r); else passes++;
        frames(7);
        checks++; if ({score_r, score_l} !== {4'd1, 4'd0})
            $display("[TB] FAIL miss_score: got r=%0d l=%0d expected r=1 l=0", score_r, score_l); else passes++;
        checks++; if ({dut.ball_x, dut.ball_y, dut.dx_pos, dut.dy_pos, dut.state} !== {12'd395, 12'd295, 1'b0, 1'b1, 2'd0})
            $display("[TB] FAIL miss_recentre: got (%0d,%0d) dx%0b dy%0b st%0d expected (395,295) dx0 dy1 st0",
                     dut.ball_x, dut.ball_y, dut.dx_pos, dut.dy_pos, dut.state); else passes++;
    endtask

    task automatic test_left_paddle();
        do_reset();
        r_dn = 1'b1; l_up = 1'b1;
        frames(7);
        l_up = 1'b0;
        frames(53);
        checks++; if (dut.paddle_l_y !== 10'd218) $display("[TB] FAIL left_setup: got %0d expected 218", dut.paddle_l_y); else passes++;
        r_dn = 1'b0;
        frames(275);
        checks++; if ({dut.ball_x, dut.ball_y, dut.dx_pos, score_r} !== {12'd30, 12'd212, 1'b1, 4'd0})
            $display("[TB] FAIL left_paddle_hit: got (%0d,%0d) dx%0b r=%0d expected (30,212) dx1 r=0",
                     dut.ball_x, dut.ball_y, dut.dx_pos, score_r); else passes++;
        frames(1);
        checks++; if ({dut.ball_x, dut.ball_y} !== {12'd34, 12'd216})
            $display("[TB] FAIL left_rebound: got (%0d,%0d) expected (34,216)", dut.ball_x, dut.ball_y); else passes++;
    endtask

    task automatic test_game_over();
        do_reset();
        frames(159);
        checks++; if ({score_l, dut.state, dut.dx_pos, dut.dy_pos} !== {4'd1, 2'd0, 1'b1, 1'b0})
            $display("[TB] FAIL first_point: got l=%0d st%0d dx%0b dy%0b expected l=1 st0 dx1 dy0",
                     score_l, dut.state, dut.dx_pos, dut.dy_pos); else passes++;
        for (int p = 2; p <= 8; p++) frames(159);
        checks++; if ({score_l, score_r, game_over} !== {4'd8, 4'd0, 1'b0})
            $display("[TB] FAIL eight_points: got l=%0d r=%0d go=%0b expected 8/0/0", score_l, score_r, game_over); else passes++;
        frames(159);
        checks++; if ({score_l, game_over, dut.state} !== {4'd9, 1'b1, 2'd2})
            $display("[TB] FAIL win: got l=%0d go=%0b st%0d expected 9/1/2", score_l, game_over, dut.state); else passes++;
        frames(5);
        checks++; if ({dut.ball_x, dut.ball_y, score_l, game_over} !== {12'd395, 12'd295, 4'd9, 1'b1})
            $display("[TB] FAIL frozen: got (%0d,%0d) l=%0d go=%0b expected (395,295) 9 1",
                     dut.ball_x, dut.ball_y, score_l, game_over); else passes++;
        x = 11'd100; y = 10'd100; active = 1'b1;
        step();
        checks++; if (rgb !== 12'h400) $display("[TB] FAIL over_background: got %h expected 400", rgb); else passes++;
        active = 1'b0;
        r_dn = 1'b1;
        frames(1);
        r_dn = 1'b0;
        checks++; if ({score_l, score_r, game_over, dut.state} !== {4'd0, 4'd0, 1'b0, 2'd0})
            $display("[TB] FAIL restart: got l=%0d r=%0d go=%0b st%0d expected 0/0/0/0",
                     score_l, score_r, game_over, dut.state); else passes++;
        checks++; if ({dut.paddle_r_y, dut.dx_pos, dut.dy_pos} !== {10'd260, 1'b1, 1'b1})
            $display("[TB] FAIL restart_paddle_dir: got %0d dx%0b dy%0b expected 260 dx1 dy1",
                     dut.paddle_r_y, dut.dx_pos, dut.dy_pos); else passes++;
    endtask

    logic [10:0] vx [14] = '{11'd400, 11'd399, 11'd400, 11'd401, 11'd395, 11'd404, 11'd405,
                             11'd394, 11'd20,  11'd29,  11'd30,  11'd19,  11'd770, 11'd779};
    logic [9:0]  vy [14] = '{10'd0,   10'd15,  10'd16,  10'd0,   10'd295, 10'd304, 10'd304,
                             10'd295, 10'd260, 10'd339, 10'd300, 10'd300, 10'd300, 10'd340};
    logic [11:0] vexp [14] = '{12'h888, 12'h888, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000,
                               12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000};

    task automatic test_render();
        do_reset();
        x = 11'd400; y = 10'd0; active = 1'b1;
        #1;
        checks++; if (rgb !== 12'h000) $display("[TB] FAIL render_latency: got %h expected 000", rgb); else passes++;
        for (int i = 0; i < 14; i++) begin
            x = vx[i]; y = vy[i]; active = 1'b1;
            step();
            checks++; if (rgb !== vexp[i])
                $display("[TB] FAIL render_%0d (%0d,%0d): got %h expected %h", i, vx[i], vy[i], rgb, vexp[i]); else passes++;
        end
        x = 11'd400; y = 10'd0; active = 1'b0;
        step();
        checks++; if (rgb !== 12'h000) $display("[TB] FAIL render_inactive: got %h expected 000", rgb); else passes++;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_serve();
        test_paddle();
        test_bounce_and_miss();
        test_left_paddle();
        test_game_over();
        test_render();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
